// File: rtl/dmem_arbiter.sv
// Two-requester arbiter and access sequencer for a single-port synchronous RAM.
// D (load/store) has priority; I (fetch) is forced through after STARVE_LIMIT D grants.
module dmem_arbiter #(
    parameter int unsigned SIZE         = 10,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            d_req,
    input  logic [31:0]     d_addr,
    input  logic [2:0]      d_ctrl,
    input  logic [31:0]     d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [31:0]     d_rdata,
    output logic            d_err,

    input  logic            i_req,
    input  logic [31:0]     i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [31:0]     i_rdata,
    output logic            i_err,

    output logic            mem_en,
    output logic            mem_we,
    output logic [3:0]      mem_be,
    output logic [SIZE-1:0] mem_addr,
    output logic [31:0]     mem_wdata,
    input  logic [31:0]     mem_rdata
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned ADDR_W = SIZE + 2;

    localparam logic [2:0] CTRL_LB  = 3'b000;
    localparam logic [2:0] CTRL_LH  = 3'b001;
    localparam logic [2:0] CTRL_LW  = 3'b010;
    localparam logic [2:0] CTRL_LBU = 3'b011;
    localparam logic [2:0] CTRL_LHU = 3'b100;
    localparam logic [2:0] CTRL_SB  = 3'b101;
    localparam logic [2:0] CTRL_SH  = 3'b110;
    localparam logic [2:0] CTRL_SW  = 3'b111;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_e;

    logic             gnt_d_c;
    logic             gnt_i_c;
    logic             force_i_c;
    logic [CNT_W-1:0] starve_cnt_d, starve_cnt_q;

    logic [2:0]        acc_ctrl_c;
    logic [ADDR_W-1:0] acc_addr_c;
    logic [1:0]        acc_off_c;
    acc_size_e         acc_size_c;
    logic              acc_store_c;
    logic              acc_misaligned_c;
    logic              acc_any_gnt_c;

    logic        d_rvalid_d, d_rvalid_q;
    logic        i_rvalid_d, i_rvalid_q;
    logic [2:0]  rsp_ctrl_d, rsp_ctrl_q;
    logic [1:0]  rsp_off_d,  rsp_off_q;
    logic        rsp_err_d,  rsp_err_q;

    logic [7:0]  rsp_byte_c;
    logic [15:0] rsp_half_c;
    logic [31:0] load_data_c;

    logic        unused_addr_bits;

    assign unused_addr_bits = ^{d_addr[31:ADDR_W], i_addr[31:ADDR_W]};

    // Arbitration: D wins unless I has waited through STARVE_LIMIT D grants; nothing granted in reset.
    always_comb begin
        force_i_c = i_req && (starve_cnt_q == CNT_W'(STARVE_LIMIT));
        gnt_i_c   = rst_n && i_req && (!d_req || force_i_c);
        gnt_d_c   = rst_n && d_req && !gnt_i_c;
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!i_req || gnt_i_c) begin
            starve_cnt_d = '0;
        end else if (gnt_d_c && (starve_cnt_q != CNT_W'(STARVE_LIMIT))) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    // Decode the granted access: size, direction and alignment.
    always_comb begin
        acc_any_gnt_c = gnt_d_c || gnt_i_c;
        acc_ctrl_c    = gnt_i_c ? CTRL_LW : d_ctrl;
        acc_addr_c    = gnt_i_c ? i_addr[ADDR_W-1:0] : d_addr[ADDR_W-1:0];
        acc_off_c     = acc_addr_c[1:0];
        acc_store_c   = 1'b0;
        acc_size_c    = SZ_WORD;
        unique case (acc_ctrl_c)
            CTRL_LB, CTRL_LBU: acc_size_c = SZ_BYTE;
            CTRL_LH, CTRL_LHU: acc_size_c = SZ_HALF;
            CTRL_LW:           acc_size_c = SZ_WORD;
            CTRL_SB: begin
                acc_size_c  = SZ_BYTE;
                acc_store_c = 1'b1;
            end
            CTRL_SH: begin
                acc_size_c  = SZ_HALF;
                acc_store_c = 1'b1;
            end
            CTRL_SW: begin
                acc_size_c  = SZ_WORD;
                acc_store_c = 1'b1;
            end
            default: acc_size_c = SZ_WORD;
        endcase
        acc_misaligned_c = ((acc_size_c == SZ_HALF) && acc_off_c[0]) ||
                           ((acc_size_c == SZ_WORD) && (acc_off_c != 2'b00));
    end

    // RAM strobes; everything stays zero when idle or when the access is misaligned.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        if (acc_any_gnt_c && !acc_misaligned_c) begin
            mem_en   = 1'b1;
            mem_we   = acc_store_c;
            mem_addr = acc_addr_c[ADDR_W-1:2];
            unique case (acc_size_c)
                SZ_BYTE: mem_be = 4'b0001 << acc_off_c;
                SZ_HALF: mem_be = 4'b0011 << acc_off_c;
                default: mem_be = 4'b1111;
            endcase
            if (acc_store_c) begin
                unique case (acc_size_c)
                    SZ_BYTE: mem_wdata = {4{d_wdata[7:0]}};
                    SZ_HALF: mem_wdata = {2{d_wdata[15:0]}};
                    default: mem_wdata = d_wdata;
                endcase
            end
        end
    end

    always_comb begin
        d_gnt      = gnt_d_c;
        i_gnt      = gnt_i_c;
        d_rvalid_d = gnt_d_c;
        i_rvalid_d = gnt_i_c;
        rsp_ctrl_d = acc_ctrl_c;
        rsp_off_d  = acc_off_c;
        rsp_err_d  = acc_any_gnt_c && acc_misaligned_c;
    end

    // Single-entry response stage: the response always lands one cycle after the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
            d_rvalid_q   <= 1'b0;
            i_rvalid_q   <= 1'b0;
            rsp_ctrl_q   <= 3'b000;
            rsp_off_q    <= 2'b00;
            rsp_err_q    <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            d_rvalid_q   <= d_rvalid_d;
            i_rvalid_q   <= i_rvalid_d;
            rsp_ctrl_q   <= rsp_ctrl_d;
            rsp_off_q    <= rsp_off_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // Lane select by the registered offset, then sign/zero extend.
    always_comb begin
        rsp_byte_c  = 8'(mem_rdata >> {rsp_off_q, 3'b000});
        rsp_half_c  = rsp_off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_data_c = 32'h0;
        unique case (rsp_ctrl_q)
            CTRL_LB:  load_data_c = {{24{rsp_byte_c[7]}}, rsp_byte_c};
            CTRL_LH:  load_data_c = {{16{rsp_half_c[15]}}, rsp_half_c};
            CTRL_LW:  load_data_c = mem_rdata;
            CTRL_LBU: load_data_c = {24'h0, rsp_byte_c};
            CTRL_LHU: load_data_c = {16'h0, rsp_half_c};
            default:  load_data_c = 32'h0;
        endcase
    end

    always_comb begin
        d_rvalid = d_rvalid_q;
        i_rvalid = i_rvalid_q;
        d_err    = d_rvalid_q && rsp_err_q;
        i_err    = i_rvalid_q && rsp_err_q;
        d_rdata  = (d_rvalid_q && !rsp_err_q) ? load_data_c : 32'h0;
        i_rdata  = (i_rvalid_q && !rsp_err_q) ? mem_rdata : 32'h0;
    end

endmodule
